mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Handshaked front-end between the multicycle main controller and the shared
//  instruction/data memory. Turns the controller's per-state memory strobes into
//  a req/ack bus transaction, stalls the controller until data returns, and owns
//  the instruction register (IR), old-PC register and memory data register (MDR).
// PARAMETERS
//  XLEN      32  data/address width
//  TIMEOUT   16  max WAIT cycles before bus error (only with MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  acc_req    in   1     controller requests an access; held high while stall=1
//  acc_we     in   1     1=store, 0=load/fetch (controller memWrite)
//  adr_src    in   1     0=address from pc, 1=address from alu_out
//  ir_write   in   1     fetch: read data goes to IR, pc goes to old_pc
//  pc         in   XLEN  current PC
//  alu_out    in   XLEN  data address
//  wdata      in   XLEN  store data
//  stall      out  1     controller must hold its state
//  instr      out  XLEN  instruction register
//  old_pc     out  XLEN  PC of the instruction in instr
//  mdr        out  XLEN  memory data register (loads)
//  align_err  out  1     one-cycle pulse: misaligned access dropped
//  bus_err    out  1     one-cycle pulse: timeout (MEM_TIMEOUT_EN only, else 0)
//  mem_req    out  1     bus request
//  mem_we     out  1     bus write enable
//  mem_addr   out  XLEN  bus address, word-aligned
//  mem_wdata  out  XLEN  bus write data
//  mem_rdata  in   XLEN  bus read data, valid with mem_ack
//  mem_ack    in   1     bus completion, single-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE; instr=32'h00000013 (nop); old_pc, mdr, mem_addr,
//   mem_wdata=0; mem_req, mem_we, stall, align_err, bus_err=0.
//  States: IDLE, WAIT, DONE.
//  IDLE: stall=acc_req. On acc_req: latch addr=(adr_src?alu_out:pc), we=acc_we,
//   wdata, ir_write, pc. If addr[1:0]!=0 -> pulse align_err, go DONE without a
//   bus cycle and without updating any register; else go WAIT.
//  WAIT: mem_req=1; mem_addr/mem_we/mem_wdata held stable; stall=1.
//   On mem_ack: read & ir_write -> instr<=mem_rdata, old_pc<=latched pc;
//   read & !ir_write -> mdr<=mem_rdata; write -> no register update. Go DONE.
//  DONE: stall=0 (controller advances on this edge); mem_req=0; go IDLE.
//  Latency: acc_req rise to stall fall = 2 cycles + WAIT cycles (min 3 edges).
//  mem_ack outside WAIT is ignored. acc_req dropped while in WAIT: transaction
//   still completes (bus cycle never aborted).
//  Back-to-back: acc_req high in the cycle after DONE starts a new access.
//  Reset mid-WAIT: mem_req drops asynchronously; captured registers keep reset values.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT
//   cycle; reaching TIMEOUT without ack -> pulse bus_err, drop mem_req, go DONE,
//   no register update. Undefined: no counter, bus_err tied 0, WAIT waits forever.
// STRUCTURE
//  Package mem_if_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2),
//   NOP_INSTR=32'h00000013, XLEN default.
//  No sub-module; timeout counter inline under `ifdef MEM_TIMEOUT_EN.
// TESTING
//  Fetch: acc_req=1,ir_write=1,pc=0x40, ack 2 cycles after req, rdata=0x00500093
//   -> mem_addr=0x40, instr=0x00500093, old_pc=0x40, stall low exactly 1 cycle.
//  Load: adr_src=1,alu_out=0x100, ack immediate, rdata=0xDEADBEEF -> mdr=0xDEADBEEF,
//   instr unchanged.
//  Store: acc_we=1,alu_out=0x104,wdata=0x1234 -> mem_we=1,mem_wdata=0x1234 held to ack;
//   mdr/instr unchanged.
//  Misaligned: alu_out=0x102 -> align_err pulse, mem_req never asserted, stall falls next cycle.
//  Reset asserted mid-WAIT -> mem_req=0 immediately, instr=0x00000013, state IDLE.
//  MEM_TIMEOUT_EN, TIMEOUT=16, no ack -> bus_err pulse after 16 WAIT cycles, stall falls.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory access unit: FSM encoding, reset
// instruction and default datapath width.
// Imported by mem_access_unit.
package mem_if_pkg;

    localparam int XLEN_DEF = 32;

    // addi x0, x0, 0: IR reset value so the decoder sees a harmless opcode
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Purpose : req/ack front-end between the multicycle controller and the shared
//           I/D memory; owns IR, old-PC and MDR.
// Latency : acc_req to stall release = 2 cycles + bus wait cycles (min 3 edges).
// Backpr. : stall holds the controller in IDLE(with acc_req)/WAIT; drops in DONE.
// Ports   : clk/rst (async, active-high); controller side acc_req, acc_we,
//           adr_src, ir_write, pc, alu_out, wdata -> stall, instr, old_pc, mdr,
//           align_err, bus_err; bus side mem_req/we/addr/wdata, mem_rdata/ack.
// Config  : define MEM_TIMEOUT_EN to enable the WAIT timeout (parameter TIMEOUT)
//           and the bus_err pulse; otherwise WAIT waits indefinitely.
module mem_access_unit
    import mem_if_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            acc_req,
    input  logic            acc_we,
    input  logic            adr_src,
    input  logic            ir_write,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] mdr,
    output logic            align_err,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] old_pc_q, old_pc_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic            we_q, we_d;
    logic            irw_q, irw_d;
    logic            align_err_q, align_err_d;
    logic            bus_err_q, bus_err_d;
    logic            stall_c;
    logic [XLEN-1:0] req_addr;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign req_addr = adr_src ? alu_out : pc;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        we_d        = we_q;
        irw_d       = irw_q;
        instr_d     = instr_q;
        old_pc_d    = old_pc_q;
        mdr_d       = mdr_q;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        stall_c     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                stall_c = acc_req;
                if (acc_req) begin
                    if (req_addr[1:0] != 2'b00) begin
                        // Misaligned: no bus cycle, bus-side latches keep
                        // their last aligned value.
                        align_err_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        addr_d  = req_addr;
                        we_d    = acc_we;
                        wdata_d = wdata;
                        irw_d   = ir_write;
                        pc_d    = pc;
                        state_d = WAIT;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    if (!we_q) begin
                        if (irw_q) begin
                            instr_d  = mem_rdata;
                            old_pc_d = pc_q;
                        end else begin
                            mdr_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // cnt_q counts completed WAIT cycles; the last allowed one
                // is TIMEOUT-1, so exactly TIMEOUT cycles are spent waiting.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            we_q        <= 1'b0;
            irw_q       <= 1'b0;
            instr_q     <= XLEN'(NOP_INSTR);
            old_pc_q    <= '0;
            mdr_q       <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            we_q        <= we_d;
            irw_q       <= irw_d;
            instr_q     <= instr_d;
            old_pc_q    <= old_pc_d;
            mdr_q       <= mdr_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Decoded from state so an async reset drops the request immediately.
    assign mem_req   = (state_q == WAIT);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall     = stall_c;
    assign instr     = instr_q;
    assign old_pc    = old_pc_q;
    assign mdr       = mdr_q;
    assign align_err = align_err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose : directed bench for mem_access_unit with a queue-based scoreboard.
// Latency : n/a (drives the controller and bus sides, checks at negedge).
// Backpr. : bus responder acks after a per-access delay (negative = never).
module tb_mem_access_unit;

    localparam int          TB_TIMEOUT = 16;
    localparam logic [31:0] NOP        = 32'h00000013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] old_pc;
        logic [31:0] mdr;
        logic        align_err;
        logic        bus_err;
        int          stall_cyc;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    logic        clk, rst;
    logic        acc_req, acc_we, adr_src, ir_write;
    logic [31:0] pc, alu_out, wdata;
    logic        stall, align_err, bus_err;
    logic [31:0] instr, old_pc, mdr;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    txn_t exp_q[$];
    bus_t bus_q[$];

    int          checks   = 0;
    int          failures = 0;
    int          resp_delay = -1;
    logic [31:0] resp_data  = '0;
    bit          stray_ack  = 1'b0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_oldpc = '0;
    logic [31:0] m_mdr   = '0;

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .acc_req   (acc_req),
        .acc_we    (acc_we),
        .adr_src   (adr_src),
        .ir_write  (ir_write),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .stall     (stall),
        .instr     (instr),
        .old_pc    (old_pc),
        .mdr       (mdr),
        .align_err (align_err),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus responder: counts WAIT cycles and pulses mem_ack at resp_delay.
    initial begin
        int rcnt;
        rcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end else if (mem_req) begin
                if (resp_delay >= 0 && rcnt == resp_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = resp_data;
                end else begin
                    mem_ack = 1'b0;
                end
                rcnt++;
            end else begin
                mem_ack = 1'b0;
                rcnt    = 0;
            end
        end
    end

    // Transaction monitor: each stall release closes one access.
    int  scnt   = 0;
    bit  s_prev = 1'b0;
    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            s_prev = 1'b0;
            scnt   = 0;
        end else if (stall) begin
            chk("err_while_stalled", {30'd0, align_err, bus_err}, 32'd0);
            s_prev = 1'b1;
            scnt++;
        end else if (s_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL txn_unexpected: stall released with no access pending");
            end else begin
                t = exp_q.pop_front();
                chk("instr",     instr,            t.instr);
                chk("old_pc",    old_pc,           t.old_pc);
                chk("mdr",       mdr,              t.mdr);
                chk("align_err", {31'd0, align_err}, {31'd0, t.align_err});
                chk("bus_err",   {31'd0, bus_err},   {31'd0, t.bus_err});
                chk("stall_cycles", 32'(scnt),     32'(t.stall_cyc));
            end
            s_prev = 1'b0;
            scnt   = 0;
        end else begin
            chk("err_idle", {30'd0, align_err, bus_err}, 32'd0);
        end
    end

    // Bus monitor: request fields must match the issued access every cycle.
    always @(negedge clk) begin
        bus_t b;
        if (!rst && mem_req) begin
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected: mem_req=1 addr=0x%0h with no bus access expected", mem_addr);
            end else begin
                b = bus_q[0];
                chk("bus_hold", {mem_addr[31:1], 1'b0} ^ {31'd0, mem_we},
                    {b.addr[31:1], 1'b0} ^ {31'd0, b.we});
                chk("bus_wdata", mem_wdata, b.wdata);
                if (mem_ack) begin
                    chk("bus_addr_at_ack", mem_addr, b.addr);
                    chk("bus_we_at_ack", {31'd0, mem_we}, {31'd0, b.we});
                    void'(bus_q.pop_front());
                end
            end
        end
    end

    // Issue one access at posedge+1; returns at posedge+1 after DONE with
    // acc_req still high so a following call is back-to-back.
    task automatic access(input logic we_v, input logic src_v, input logic irw_v,
                          input logic [31:0] pc_v, input logic [31:0] alu_v,
                          input logic [31:0] wd_v, input int dly,
                          input logic [31:0] rd, input bit drop_early);
        logic [31:0] a;
        txn_t        t;
        bus_t        b;
        int          n;
        a           = src_v ? alu_v : pc_v;
        t.align_err = (a[1:0] != 2'b00);
        t.bus_err   = 1'b0;
        if (t.align_err) begin
            t.stall_cyc = 1;
        end else if (dly < 0) begin
            t.bus_err   = 1'b1;
            t.stall_cyc = 1 + TB_TIMEOUT;
        end else begin
            t.stall_cyc = dly + 2;
            if (!we_v) begin
                if (irw_v) begin
                    m_instr = rd;
                    m_oldpc = pc_v;
                end else begin
                    m_mdr = rd;
                end
            end
        end
        t.instr  = m_instr;
        t.old_pc = m_oldpc;
        t.mdr    = m_mdr;
        exp_q.push_back(t);
        if (!t.align_err) begin
            b.addr  = a;
            b.we    = we_v;
            b.wdata = wd_v;
            bus_q.push_back(b);
        end
        resp_delay = dly;
        resp_data  = rd;
        acc_we     = we_v;
        adr_src    = src_v;
        ir_write   = irw_v;
        pc         = pc_v;
        alu_out    = alu_v;
        wdata      = wd_v;
        acc_req    = 1'b1;
        if (drop_early) begin
            @(posedge clk);
            #1;
            acc_req = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_release", {31'd0, stall}, 32'd0);
        if (dly < 0) bus_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        acc_req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        acc_req  = 1'b0;
        acc_we   = 1'b0;
        adr_src  = 1'b0;
        ir_write = 1'b0;
        pc       = '0;
        alu_out  = '0;
        wdata    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr",     instr,     NOP);
        chk("rst_old_pc",    old_pc,    32'd0);
        chk("rst_mdr",       mdr,       32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ctrl", {27'd0, mem_req, mem_we, stall, align_err, bus_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // fetch (ack on 3rd WAIT cycle), then back-to-back load
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 2, 32'h00500093, 1'b0);
        chk("b2b_stall_low_one_cycle", {31'd0, stall}, 32'd1);
        access(1'b0, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        idle(2);
        // store held until ack
        access(1'b1, 1'b1, 1'b0, 32'h44, 32'h104, 32'h1234, 3, 32'hFFFFFFFF, 1'b0);
        idle(1);
        // misaligned data and fetch addresses
        access(1'b0, 1'b1, 1'b0, 32'h44, 32'h102, 32'h0, 0, 32'h11111111, 1'b0);
        access(1'b0, 1'b0, 1'b1, 32'h41, 32'h0, 32'h0, 0, 32'h22222222, 1'b0);
        // aligned fetch right after a misaligned one
        access(1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h0, 1, 32'h00A00113, 1'b0);
        idle(1);
        // acc_req dropped in WAIT: the load still completes
        access(1'b0, 1'b1, 1'b0, 32'h48, 32'h200, 32'h0, 3, 32'h0BADF00D, 1'b1);
        idle(2);

        // mem_ack while idle must be ignored
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        idle(2);
        chk("stray_instr", instr, m_instr);
        chk("stray_mdr",   mdr,   m_mdr);
        chk("stray_idle",  {30'd0, mem_req, stall}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        access(1'b0, 1'b1, 1'b0, 32'h4C, 32'h400, 32'h0, -1, 32'h0, 1'b0);
        idle(2);
`endif

        // reset asserted in the middle of a never-acked WAIT
        resp_delay = -1;
        begin
            bus_t b;
            b.addr  = 32'h300;
            b.we    = 1'b0;
            b.wdata = 32'h0;
            bus_q.push_back(b);
        end
        adr_src  = 1'b1;
        ir_write = 1'b0;
        acc_we   = 1'b0;
        alu_out  = 32'h300;
        wdata    = 32'h0;
        acc_req  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        rst     = 1'b1;
        acc_req = 1'b0;
        #1;
        chk("midwait_rst_req",    {31'd0, mem_req}, 32'd0);
        chk("midwait_rst_instr",  instr,  NOP);
        chk("midwait_rst_old_pc", old_pc, 32'd0);
        chk("midwait_rst_mdr",    mdr,    32'd0);
        chk("midwait_rst_stall",  {31'd0, stall}, 32'd0);
        bus_q.delete();
        m_instr = NOP;
        m_oldpc = '0;
        m_mdr   = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_idle", {30'd0, mem_req, stall}, 32'd0);
        @(posedge clk);
        #1;

        // a fresh access works after the mid-WAIT reset
        access(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 1, 32'hCAFEF00D, 1'b0);
        idle(3);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
